// File: rtl/reg_40xx_wr_arb_pkg.sv
// Shared constants and helpers for the register-file write-port arbiter.
package reg_40xx_wr_arb_pkg;

  localparam int NUM_SRC   = 3;
  localparam int NUM_WORDS = 40;
  localparam int ADDR_W    = 6;

  typedef logic [1:0]        src_idx_t;
  typedef logic [ADDR_W-1:0] word_addr_t;

  // Source indices; the position of each source in src_valid/src_addr/src_data.
  localparam src_idx_t SRC_SALU = 2'd0;
  localparam src_idx_t SRC_VALU = 2'd1;
  localparam src_idx_t SRC_LSU  = 2'd2;

  // Source that sits 'off' places after 'base' in the circular search order.
  function automatic src_idx_t src_after(src_idx_t base, int off);
    return src_idx_t'((int'(base) + off) % NUM_SRC);
  endfunction

  // Only words 0..NUM_WORDS-1 exist in the register file.
  function automatic logic addr_legal(word_addr_t addr);
    return addr < word_addr_t'(NUM_WORDS);
  endfunction

  // One-hot word decode; out-of-range addresses decode to nothing.
  function automatic logic [NUM_WORDS-1:0] word_onehot(word_addr_t addr);
    logic [NUM_WORDS-1:0] vec;
    vec = '0;
    if (addr_legal(addr)) vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_40xx_wr_fifo.sv
// Per-source synchronous FIFO of {addr, data} write requests. Exposes the
// head entry, the occupancy, and every slot's valid/addr so the parent can
// build the pending-write vector without extra bookkeeping.
module reg_40xx_wr_fifo
  import reg_40xx_wr_arb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [ADDR_W-1:0]                push_addr,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [ADDR_W-1:0]                head_addr,
  output logic [WIDTH-1:0]                 head_data,
  output logic [$clog2(DEPTH):0]           count,
  output logic                             full,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]     ent_addr
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [WIDTH-1:0]  mem_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  valid_nxt;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & (count != '0);

  // Per-slot valid bits: clear the slot being read, set the slot being written.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    valid_nxt = valid_q;
    if (do_pop)  valid_nxt[rd_ptr] = 1'b0;
    if (do_push) valid_nxt[wr_ptr] = 1'b1;
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the valid bits and count gate every use of it.
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and slot-valid state.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_addr = mem_addr[rd_ptr];
  assign head_data = mem_data[rd_ptr];
  assign ent_valid = valid_q;

  // Flatten the slot addresses for the pending decode.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_addr[i] = mem_addr[i];
  end

endmodule

// File: rtl/reg_40xx_wr_arb.sv
// Write-port arbiter for the 40-word, 2-write-port register file. Buffers
// SALU/VALU/LSU requests per source, picks up to two heads per cycle in
// round-robin order with distinct addresses, and exports pending writes.
module reg_40xx_wr_arb
  import reg_40xx_wr_arb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               src_valid,
  output logic [2:0]               src_ready,
  input  logic [17:0]              src_addr,
  input  logic [3*WIDTH-1:0]       src_data,
  output logic                     wr0_en,
  output logic                     wr1_en,
  output logic [5:0]               wr0_addr,
  output logic [5:0]               wr1_addr,
  output logic [WIDTH-1:0]         wr0_data,
  output logic [WIDTH-1:0]         wr1_data,
  output logic [39:0]              pending,
  output logic                     illegal_addr
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0]               in_addr   [NUM_SRC];
  logic [WIDTH-1:0]                in_data   [NUM_SRC];
  logic [ADDR_W-1:0]               head_addr [NUM_SRC];
  logic [WIDTH-1:0]                head_data [NUM_SRC];
  logic [CNT_W-1:0]                fifo_cnt  [NUM_SRC];
  logic [DEPTH-1:0]                ent_valid [NUM_SRC];
  logic [DEPTH-1:0][ADDR_W-1:0]    ent_addr  [NUM_SRC];
  logic [NUM_SRC-1:0]              fifo_full;
  logic [NUM_SRC-1:0]              head_valid;
  logic [NUM_SRC-1:0]              accept;
  logic [NUM_SRC-1:0]              push;
  logic [NUM_SRC-1:0]              pop;
  logic                            illegal_hit;

  src_idx_t                        rr;
  src_idx_t                        rr_nxt;
  src_idx_t                        grant_a;
  src_idx_t                        grant_b;
  logic                            grant_a_vld;
  logic                            grant_b_vld;
  logic [NUM_WORDS-1:0]            pending_vec;

  // Ready comes from registered occupancy only and is held low during reset.
  assign src_ready = ~fifo_full & {NUM_SRC{rst}};
  assign accept    = src_valid & src_ready;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    assign in_addr[k]    = src_addr[ADDR_W*k +: ADDR_W];
    assign in_data[k]    = src_data[WIDTH*k +: WIDTH];
    assign head_valid[k] = (fifo_cnt[k] != '0);

    reg_40xx_wr_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[k]),
      .push_addr (in_addr[k]),
      .push_data (in_data[k]),
      .pop       (pop[k]),
      .head_addr (head_addr[k]),
      .head_data (head_data[k]),
      .count     (fifo_cnt[k]),
      .full      (fifo_full[k]),
      .ent_valid (ent_valid[k]),
      .ent_addr  (ent_addr[k])
    );
  end

  // Illegal-address filter: accepted requests to words >= 40 are dropped.
  always_comb begin
    push        = '0;
    illegal_hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (accept[k]) begin
        if (addr_legal(in_addr[k])) push[k] = 1'b1;
        else                        illegal_hit = 1'b1;
      end
    end
  end

  // Round-robin pick of grant A, then the next head with a different word as grant B.
  always_comb begin
    src_idx_t s;
    grant_a_vld = 1'b0;
    grant_b_vld = 1'b0;
    grant_a     = SRC_SALU;
    grant_b     = SRC_SALU;
    s           = SRC_SALU;
    for (int j = 0; j < NUM_SRC; j++) begin
      s = src_after(rr, j);
      if (head_valid[s]) begin
        if (!grant_a_vld) begin
          grant_a_vld = 1'b1;
          grant_a     = s;
        end else if (!grant_b_vld && (head_addr[s] != head_addr[grant_a])) begin
          grant_b_vld = 1'b1;
          grant_b     = s;
        end
      end
    end
  end

  // Pop the granted heads and advance the pointer past the last granted source.
  always_comb begin
    pop    = '0;
    rr_nxt = rr;
    if (grant_a_vld) begin
      pop[grant_a] = 1'b1;
      rr_nxt       = src_after(grant_a, 1);
    end
    if (grant_b_vld) begin
      pop[grant_b] = 1'b1;
      rr_nxt       = src_after(grant_b, 1);
    end
  end

  // Registered write ports, round-robin pointer and illegal-address pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr           <= SRC_SALU;
      wr0_en       <= 1'b0;
      wr1_en       <= 1'b0;
      wr0_addr     <= '0;
      wr1_addr     <= '0;
      wr0_data     <= '0;
      wr1_data     <= '0;
      illegal_addr <= 1'b0;
    end else begin
      rr           <= rr_nxt;
      illegal_addr <= illegal_hit;
      wr0_en       <= grant_a_vld;
      wr1_en       <= grant_b_vld;
      if (grant_a_vld) begin
        wr0_addr <= head_addr[grant_a];
        wr0_data <= head_data[grant_a];
      end
      if (grant_b_vld) begin
        wr1_addr <= head_addr[grant_b];
        wr1_data <= head_data[grant_b];
      end
    end
  end

  // Pending words: every buffered entry plus every port driving this cycle.
  always_comb begin
    pending_vec = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_valid[k][i]) pending_vec |= word_onehot(ent_addr[k][i]);
      end
    end
    if (wr0_en) pending_vec |= word_onehot(wr0_addr);
    if (wr1_en) pending_vec |= word_onehot(wr1_addr);
  end

  assign pending = pending_vec;

endmodule

// File: tb/tb_reg_40xx_wr_arb.sv
// Directed self-checking bench for reg_40xx_wr_arb (WIDTH=64, DEPTH=2).
module tb_reg_40xx_wr_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   src_valid;
  logic [2:0]   src_ready;
  logic [17:0]  src_addr;
  logic [191:0] src_data;
  logic         wr0_en, wr1_en;
  logic [5:0]   wr0_addr, wr1_addr;
  logic [63:0]  wr0_data, wr1_data;
  logic [39:0]  pending;
  logic         illegal_addr;

  int checks   = 0;
  int failures = 0;

  reg_40xx_wr_arb #(.WIDTH(64), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_addr     (src_addr),
    .src_data     (src_data),
    .wr0_en       (wr0_en),
    .wr1_en       (wr1_en),
    .wr0_addr     (wr0_addr),
    .wr1_addr     (wr1_addr),
    .wr0_data     (wr0_data),
    .wr1_data     (wr1_data),
    .pending      (pending),
    .illegal_addr (illegal_addr)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int k, input logic [5:0] a, input logic [63:0] d);
    src_addr[6*k +: 6]  = a;
    src_data[64*k +: 64] = d;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    src_valid = 3'b000;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    src_valid = 3'b111;
    set_src(0, 6'd1, 64'h11);
    set_src(1, 6'd2, 64'h22);
    set_src(2, 6'd3, 64'h33);
    repeat (3) step();
    checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL reset_ready got=%b exp=000", src_ready); end
    checks++; if ({wr0_en, wr1_en} !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", {wr0_en, wr1_en}); end
    checks++; if ({wr0_addr, wr1_addr} !== 12'd0) begin failures++; $display("FAIL reset_addr got=%h exp=0", {wr0_addr, wr1_addr}); end
    checks++; if ({wr0_data, wr1_data} !== 128'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {wr0_data, wr1_data}); end
    checks++; if (pending !== 40'd0) begin failures++; $display("FAIL reset_pending got=%h exp=0", pending); end
    checks++; if (illegal_addr !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal_addr); end
    src_valid = 3'b000;
    rst       = 1'b1;
    #1;
    checks++; if (src_ready !== 3'b111) begin failures++; $display("FAIL reset_release_ready got=%b exp=111", src_ready); end
    step();
    checks++; if (pending !== 40'd0) begin failures++; $display("FAIL reset_nothing_accepted got=%h exp=0", pending); end
    checks++; if ({wr0_en, wr1_en} !== 2'b00) begin failures++; $display("FAIL reset_no_issue got=%b exp=00", {wr0_en, wr1_en}); end
  endtask

  task automatic test_collision();
    do_reset();
    set_src(0, 6'd5, 64'hAAAA_0000_0000_000A);
    set_src(1, 6'd5, 64'hBBBB_0000_0000_000B);
    src_valid = 3'b011;
    step();
    src_valid = 3'b000;
    checks++; if (pending !== (40'd1 << 5)) begin failures++; $display("FAIL coll_pending_accept got=%h exp=%h", pending, 40'd1 << 5); end
    checks++; if (wr0_en !== 1'b0) begin failures++; $display("FAIL coll_no_bypass got=%b exp=0", wr0_en); end
    step();
    checks++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 6'd5, 64'hAAAA_0000_0000_000A}) begin failures++; $display("FAIL coll_first got=%b/%0d/%h exp=1/5/A", wr0_en, wr0_addr, wr0_data); end
    checks++; if (wr1_en !== 1'b0) begin failures++; $display("FAIL coll_port1_idle_1 got=%b exp=0", wr1_en); end
    step();
    checks++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 6'd5, 64'hBBBB_0000_0000_000B}) begin failures++; $display("FAIL coll_second got=%b/%0d/%h exp=1/5/B", wr0_en, wr0_addr, wr0_data); end
    checks++; if (wr1_en !== 1'b0) begin failures++; $display("FAIL coll_port1_idle_2 got=%b exp=0", wr1_en); end
    checks++; if (pending !== (40'd1 << 5)) begin failures++; $display("FAIL coll_pending_held got=%h exp=%h", pending, 40'd1 << 5); end
    step();
    checks++; if (pending !== 40'd0) begin failures++; $display("FAIL coll_pending_clear got=%h exp=0", pending); end
    checks++; if (wr0_en !== 1'b0) begin failures++; $display("FAIL coll_done got=%b exp=0", wr0_en); end
  endtask

  task automatic test_dual_issue();
    do_reset();
    set_src(0, 6'd3, 64'h3333);
    set_src(1, 6'd7, 64'h7777);
    set_src(2, 6'd9, 64'h9999);
    src_valid = 3'b111;
    step();
    src_valid = 3'b000;
    checks++; if (pending !== ((40'd1 << 3) | (40'd1 << 7) | (40'd1 << 9))) begin failures++; $display("FAIL dual_pending_accept got=%h", pending); end
    step();
    checks++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 6'd3, 64'h3333}) begin failures++; $display("FAIL dual_port0 got=%b/%0d/%h exp=1/3/3333", wr0_en, wr0_addr, wr0_data); end
    checks++; if ({wr1_en, wr1_addr, wr1_data} !== {1'b1, 6'd7, 64'h7777}) begin failures++; $display("FAIL dual_port1 got=%b/%0d/%h exp=1/7/7777", wr1_en, wr1_addr, wr1_data); end
    checks++; if (pending !== ((40'd1 << 3) | (40'd1 << 7) | (40'd1 << 9))) begin failures++; $display("FAIL dual_pending_issue got=%h", pending); end
    step();
    checks++; if ({wr0_en, wr0_addr, wr0_data} !== {1'b1, 6'd9, 64'h9999}) begin failures++; $display("FAIL dual_lsu got=%b/%0d/%h exp=1/9/9999", wr0_en, wr0_addr, wr0_data); end
    checks++; if (wr1_en !== 1'b0) begin failures++; $display("FAIL dual_port1_idle got=%b exp=0", wr1_en); end
    checks++; if (wr1_addr !== 6'd7) begin failures++; $display("FAIL dual_port1_hold got=%0d exp=7", wr1_addr); end
    checks++; if (pending !== (40'd1 << 9)) begin failures++; $display("FAIL dual_pending_tail got=%h exp=%h", pending, 40'd1 << 9); end
    step();
    checks++; if ({wr0_en, wr1_en, pending} !== {2'b00, 40'd0}) begin failures++; $display("FAIL dual_idle got=%b%b/%h exp=00/0", wr0_en, wr1_en, pending); end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_src(0, 6'd10, 64'h5000);
    set_src(1, 6'd10, 64'hB000);
    src_valid = 3'b011;
    step();
    set_src(1, 6'd10, 64'hB001);
    src_valid = 3'b010;
    step();
    checks++; if (src_ready !== 3'b101) begin failures++; $display("FAIL bp_ready_full got=%b exp=101", src_ready); end
    checks++; if ({wr0_en, wr0_data, wr1_en} !== {1'b1, 64'h5000, 1'b0}) begin failures++; $display("FAIL bp_salu_first got=%b/%h/%b exp=1/5000/0", wr0_en, wr0_data, wr1_en); end
    set_src(1, 6'd10, 64'hB002);
    step();
    checks++; if ({wr0_en, wr0_data} !== {1'b1, 64'hB000}) begin failures++; $display("FAIL bp_valu0 got=%b/%h exp=1/B000", wr0_en, wr0_data); end
    checks++; if (src_ready[1] !== 1'b1) begin failures++; $display("FAIL bp_ready_after_pop got=%b exp=1", src_ready[1]); end
    step();
    src_valid = 3'b000;
    checks++; if ({wr0_en, wr0_data} !== {1'b1, 64'hB001}) begin failures++; $display("FAIL bp_valu1 got=%b/%h exp=1/B001", wr0_en, wr0_data); end
    step();
    checks++; if ({wr0_en, wr0_data} !== {1'b1, 64'hB002}) begin failures++; $display("FAIL bp_valu2 got=%b/%h exp=1/B002", wr0_en, wr0_data); end
    step();
    checks++; if ({wr0_en, wr1_en, pending} !== {2'b00, 40'd0}) begin failures++; $display("FAIL bp_idle got=%b%b/%h exp=00/0", wr0_en, wr1_en, pending); end
  endtask

  task automatic test_illegal_addr();
    do_reset();
    set_src(2, 6'd45, 64'hDEAD);
    src_valid = 3'b100;
    #1;
    checks++; if (src_ready[2] !== 1'b1) begin failures++; $display("FAIL ill_ready got=%b exp=1", src_ready[2]); end
    step();
    src_valid = 3'b000;
    checks++; if (illegal_addr !== 1'b1) begin failures++; $display("FAIL ill_pulse got=%b exp=1", illegal_addr); end
    checks++; if (pending !== 40'd0) begin failures++; $display("FAIL ill_pending got=%h exp=0", pending); end
    step();
    checks++; if ({illegal_addr, wr0_en, wr1_en} !== 3'b000) begin failures++; $display("FAIL ill_no_write got=%b exp=000", {illegal_addr, wr0_en, wr1_en}); end
    set_src(0, 6'd39, 64'h3939);
    set_src(2, 6'd40, 64'h4040);
    src_valid = 3'b101;
    step();
    src_valid = 3'b000;
    checks++; if (illegal_addr !== 1'b1) begin failures++; $display("FAIL ill_boundary_pulse got=%b exp=1", illegal_addr); end
    checks++; if (pending !== (40'd1 << 39)) begin failures++; $display("FAIL ill_boundary_pending got=%h exp=%h", pending, 40'd1 << 39); end
    step();
    checks++; if ({wr0_en, wr0_addr, wr0_data, wr1_en, illegal_addr} !== {1'b1, 6'd39, 64'h3939, 1'b0, 1'b0}) begin failures++; $display("FAIL ill_boundary_issue got=%b/%0d/%h/%b/%b exp=1/39/3939/0/0", wr0_en, wr0_addr, wr0_data, wr1_en, illegal_addr); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_src(0, 6'd20, 64'h2000);
    set_src(1, 6'd20, 64'h2001);
    set_src(2, 6'd20, 64'h2002);
    src_valid = 3'b111;
    step();
    set_src(0, 6'd21, 64'h2100);
    set_src(1, 6'd21, 64'h2101);
    src_valid = 3'b011;
    step();
    src_valid = 3'b000;
    checks++; if (pending !== ((40'd1 << 20) | (40'd1 << 21))) begin failures++; $display("FAIL mid_pending_before got=%h", pending); end
    rst = 1'b0;
    #1;
    checks++; if (src_ready !== 3'b000) begin failures++; $display("FAIL mid_ready_in_reset got=%b exp=000", src_ready); end
    step();
    checks++; if ({wr0_en, wr1_en, pending} !== {2'b00, 40'd0}) begin failures++; $display("FAIL mid_cleared got=%b%b/%h exp=00/0", wr0_en, wr1_en, pending); end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({wr0_en, wr1_en, pending} !== {2'b00, 40'd0}) begin failures++; $display("FAIL mid_after_%0d got=%b%b/%h exp=00/0", i, wr0_en, wr1_en, pending); end
    end
  endtask

  initial begin
    rst       = 1'b0;
    src_valid = 3'b000;
    src_addr  = '0;
    src_data  = '0;
    test_reset();
    test_collision();
    test_dual_issue();
    test_backpressure();
    test_illegal_addr();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
